ser_frame_rx: RTL and testbench

SER_FRAME_RX -- requirements
Module: ser_frame_rx

---
 rtl/ser_frame_rx.sv | 116 +++++++++++
 tb/tb_ser_frame_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ser_frame_rx.sv
// rtl/ser_frame_rx.sv - strobed serial frame receiver with optional even parity
// Receives start/8 data/[parity]/stop frames and hands bytes to a ready/valid consumer.
module ser_frame_rx #(
  parameter bit PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       frame_err_q, frame_err_d;
  logic       parity_err_q, parity_err_d;
  logic       overrun_q, overrun_d;
  logic       perr_q, perr_d;
  logic       good_frame;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shreg_d      = shreg_q;
    data_d       = data_q;
    valid_d      = valid_q & ~ready;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = overrun_q;
    perr_d       = perr_q;
    good_frame   = 1'b0;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (!din) begin
            state_d = DATA;
            cnt_d   = 3'd0;
            perr_d  = 1'b0;
          end
        end
        DATA: begin
          shreg_d = {din, shreg_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
        end
        PARITY: begin
          perr_d  = ^{shreg_q, din};
          state_d = STOP;
        end
        STOP: begin
          state_d      = IDLE;
          frame_err_d  = ~din;
          parity_err_d = PARITY_EN && perr_q;
          good_frame   = din && !(PARITY_EN && perr_q);
          // A pending byte that is not being accepted right now wins over the new one.
          if (good_frame) begin
            if (valid_q && !ready) begin
              overrun_d = 1'b1;
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      shreg_q      <= 8'h00;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shreg_q      <= shreg_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      perr_q       <= perr_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_ser_frame_rx.sv
// tb/tb_ser_frame_rx.sv - directed table-driven bench for ser_frame_rx
module tb_ser_frame_rx;

  logic       clk = 1'b0;
  logic       reset, en, din, ready;
  logic [7:0] data, np_data;
  logic       valid, busy, frame_err, parity_err, overrun;
  logic       np_valid, np_busy, np_frame_err, np_parity_err, np_overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ser_frame_rx #(.PARITY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .data(data), .valid(valid),
    .ready(ready), .busy(busy), .frame_err(frame_err), .parity_err(parity_err),
    .overrun(overrun)
  );

  ser_frame_rx #(.PARITY_EN(1'b0)) dut_np (
    .clk(clk), .reset(reset), .en(en), .din(din), .data(np_data), .valid(np_valid),
    .ready(ready), .busy(np_busy), .frame_err(np_frame_err), .parity_err(np_parity_err),
    .overrun(np_overrun)
  );

  typedef struct {
    logic [7:0] b;
    logic       p;
    logic       s;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic p, input logic s,
                            input bit with_par, input bit gap, input logic rdy_stop);
    logic [10:0] bits;
    int n;
    if (with_par) begin
      bits = {s, p, b, 1'b0};
      n = 11;
    end else begin
      bits = {1'b0, s, b, 1'b0};
      n = 10;
    end
    for (int i = 0; i < n; i++) begin
      if (gap) begin
        en  = 1'b0;
        din = ~bits[i];
        tick();
      end
      en  = 1'b1;
      din = bits[i];
      if (i == n - 1) ready = rdy_stop;
      tick();
    end
    en    = 1'b0;
    din   = 1'b1;
    ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

    reset = 1'b1; en = 1'b0; din = 1'b1; ready = 1'b0;
    tick();
    tick();
    chk("reset_data", data, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ferr", frame_err, 1'b0);
    chk("reset_perr", parity_err, 1'b0);
    chk("reset_overrun", overrun, 1'b0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].b, vecs[v].p, vecs[v].s, 1'b1, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid", v), valid, vecs[v].exp_valid);
      chk($sformatf("v%0d_data", v), data, vecs[v].exp_data);
      chk($sformatf("v%0d_ferr", v), frame_err, vecs[v].exp_ferr);
      chk($sformatf("v%0d_perr", v), parity_err, vecs[v].exp_perr);
      chk($sformatf("v%0d_busy", v), busy, 1'b0);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk($sformatf("v%0d_ferr_end", v), frame_err, 1'b0);
      chk($sformatf("v%0d_perr_end", v), parity_err, 1'b0);
      chk($sformatf("v%0d_consumed", v), valid, 1'b0);
      chk($sformatf("v%0d_overrun", v), overrun, 1'b0);
    end

    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovr_data", data, 8'h11);
    chk("ovr_valid", valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("ovr_consumed", valid, 1'b0);
    chk("ovr_sticky", overrun, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovr_reset", overrun, 1'b0);

    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sim_first", data, 8'h11);
    send_frame(8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("sim_data", data, 8'h77);
    chk("sim_valid", valid, 1'b1);
    chk("sim_overrun", overrun, 1'b0);
    ready = 1'b1;
    tick();
    ready = 1'b0;

    send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("gap_data", data, 8'h5A);
    chk("gap_valid", valid, 1'b1);

    en = 1'b1; din = 1'b0;
    tick();
    chk("mid_busy", busy, 1'b1);
    for (int i = 0; i < 4; i++) begin
      din = i[0];
      tick();
    end
    reset = 1'b1; en = 1'b1; din = 1'b0; ready = 1'b1;
    tick();
    reset = 1'b0; en = 1'b0; din = 1'b1; ready = 1'b0;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ferr", frame_err, 1'b0);
    chk("mid_rst_perr", parity_err, 1'b0);
    chk("mid_rst_overrun", overrun, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("after_rst_data", data, 8'hFF);
    chk("after_rst_valid", valid, 1'b1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("np_data", np_data, 8'hC3);
    chk("np_valid", np_valid, 1'b1);
    chk("np_perr", np_parity_err, 1'b0);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("np_ferr", np_frame_err, 1'b1);
    chk("np_data_kept", np_data, 8'hC3);
    chk("np_busy", np_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
